// File: rtl/top_pkg.sv
// Shared definitions for the button-driven accumulator.
// Contents:
//   DATA_W_DEFAULT      default width of switches, accumulator and LEDs
//   SYNC_STAGES_DEFAULT default depth of every input synchronizer
//   BTN_* indices       bit positions of the buttons in the event vector
//   op_e                opcode selected from the button events
//   pick_op()           fixed-priority encoder, u > d > l > r
package top_pkg;

  localparam int DATA_W_DEFAULT      = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam int NUM_BTNS = 4;
  localparam int BTN_R    = 0;
  localparam int BTN_L    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_U    = 3;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_SHL  = 3'd3,
    OP_LOAD = 3'd4
  } op_e;

  // Only the highest-priority event survives; the rest are dropped.
  function automatic op_e pick_op(input logic [NUM_BTNS-1:0] ev);
    op_e op;
    op = OP_NONE;
    if (ev[BTN_U])      op = OP_ADD;
    else if (ev[BTN_D]) op = OP_SUB;
    else if (ev[BTN_L]) op = OP_SHL;
    else if (ev[BTN_R]) op = OP_LOAD;
    return op;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizer plus rising-edge detector for one asynchronous button.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset, clears every flop
//   btn_i    raw asynchronous button level
//   event_o  one-cycle pulse per rising edge of the synchronized level
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= btn_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held button yields a single pulse: prev_q catches up one cycle later.
  assign event_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/top.sv
// Button-driven accumulator: four buttons select ADD/SUB/SHL/LOAD of the
// synchronized switch value into a DATA_W accumulator shown on the LEDs.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   switches  asynchronous operand bus
//   btn_u     rising edge -> ADD  (highest priority)
//   btn_d     rising edge -> SUB
//   btn_l     rising edge -> SHL
//   btn_r     rising edge -> LOAD (lowest priority)
//   leds      accumulator register, driven straight from a flop
module top
  import top_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] switches,
  input  logic              btn_u,
  input  logic              btn_d,
  input  logic              btn_l,
  input  logic              btn_r,
  output logic [DATA_W-1:0] leds
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_evt;
  logic [DATA_W-1:0]   sw_q [SYNC_STAGES];
  logic [DATA_W-1:0]   sw_sync;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   acc_d;
  op_e                 op;

  assign btn_raw[BTN_U] = btn_u;
  assign btn_raw[BTN_D] = btn_d;
  assign btn_raw[BTN_L] = btn_l;
  assign btn_raw[BTN_R] = btn_r;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_btn (
      .clk     (clk),
      .rst_n   (reset),
      .btn_i   (btn_raw[gi]),
      .event_o (btn_evt[gi])
    );
  end

  // Switches share the buttons' depth so an event sees the operand that
  // was sampled on the same edge as its button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_q[i] <= '0;
      end
    end else begin
      sw_q[0] <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_q[i] <= sw_q[i-1];
      end
    end
  end

  assign sw_sync = sw_q[SYNC_STAGES-1];
  assign op      = pick_op(btn_evt);

  // Arithmetic wraps modulo 2^DATA_W; no status is kept.
  always_comb begin
    acc_d = acc_q;
    unique case (op)
      OP_ADD:  acc_d = acc_q + sw_sync;
      OP_SUB:  acc_d = acc_q - sw_sync;
      OP_SHL:  acc_d = {acc_q[DATA_W-2:0], 1'b0};
      OP_LOAD: acc_d = sw_sync;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign leds = acc_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: a sample-history model predicts leds on
// every cycle, and literal expectations pin the results of each scenario.
module tb_top;

  localparam int W    = 16;
  localparam int S    = 2;
  localparam int MAXN = 4096;

  logic         clk;
  logic         reset;
  logic [W-1:0] switches;
  logic [3:0]   btn_v;   // {u, d, l, r}
  logic [W-1:0] leds;

  int checks;
  int failures;
  bit cmp_en;

  top #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .btn_u    (btn_v[3]),
    .btn_d    (btn_v[2]),
    .btn_l    (btn_v[1]),
    .btn_r    (btn_v[0]),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The model records what was on the inputs at every rising edge since
  // reset released. An input seen at edge n becomes usable at edge n+S, and
  // a button counts only if it was low at the edge before.
  logic [3:0]   samp_btn [MAXN];
  logic [W-1:0] samp_sw  [MAXN];
  int           n_edge;
  logic [W-1:0] m_acc;

  function automatic logic [W-1:0] model_next(input int n, input logic [W-1:0] acc);
    logic [3:0]   cur;
    logic [3:0]   prv;
    logic [3:0]   ev;
    logic [W-1:0] sw;
    cur = (n - S >= 0)     ? samp_btn[n-S]   : 4'b0;
    prv = (n - S - 1 >= 0) ? samp_btn[n-S-1] : 4'b0;
    sw  = (n - S >= 0)     ? samp_sw[n-S]    : '0;
    ev  = cur & ~prv;
    if (ev[3])      return acc + sw;
    else if (ev[2]) return acc - sw;
    else if (ev[1]) return acc << 1;
    else if (ev[0]) return sw;
    return acc;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_edge <= 0;
      m_acc  <= '0;
    end else if (n_edge < MAXN) begin
      samp_btn[n_edge] <= btn_v;
      samp_sw[n_edge]  <= switches;
      m_acc            <= model_next(n_edge, m_acc);
      n_edge           <= n_edge + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (leds !== m_acc) begin
        failures++;
        $display("FAIL cycle_model t=%0t leds=%h model=%h", $time, leds, m_acc);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string name, input logic [W-1:0] exp);
    checks++;
    if (leds !== exp) begin
      failures++;
      $display("FAIL %s leds=%h expected=%h", name, leds, exp);
    end else begin
      $display("ok   %s leds=%h", name, leds);
    end
    checks++;
    if (m_acc !== exp) begin
      failures++;
      $display("FAIL %s_model model=%h expected=%h", name, m_acc, exp);
    end
  endtask

  // Raise buttons b with operand sw for len cycles; the switches are
  // scrambled one cycle later so a wrongly timed operand sample shows up.
  task automatic pulse(input logic [3:0] b, input logic [W-1:0] sw, input int len);
    @(negedge clk); #2;
    switches = sw;
    btn_v    = b;
    for (int i = 0; i < len; i++) begin
      @(negedge clk); #2;
      if (i == 0) switches = 16'h5A5A;
    end
    btn_v = 4'b0;
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    reset    = 1'b0;
    switches = 16'hABCD;
    btn_v    = 4'hF;

    // Reset with arbitrary inputs: leds stay 0 throughout.
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("reset_hold", 16'h0000);
    end
    #1;
    btn_v = 4'b0;
    repeat (2) @(negedge clk); #2;
    reset = 1'b1;
    repeat (4) @(negedge clk); #1;
    chk("after_reset", 16'h0000);

    // ADD with a long pulse: exactly one increment.
    pulse(4'b1000, 16'h0003, 10);
    chk("add_long", 16'h0003);

    pulse(4'b0100, 16'h0003, 3);
    chk("sub_to_zero", 16'h0000);
    pulse(4'b0010, 16'h1234, 3);
    chk("shl_zero", 16'h0000);
    pulse(4'b0100, 16'h0003, 3);
    chk("sub_wrap", 16'hFFFD);

    pulse(4'b0001, 16'h8001, 3);
    chk("load", 16'h8001);
    pulse(4'b0010, 16'h0000, 2);
    chk("shl_msb_drop", 16'h0002);

    // Priority: ADD wins over LOAD.
    pulse(4'b0001, 16'h0001, 1);
    chk("load_one", 16'h0001);
    pulse(4'b1001, 16'h0005, 4);
    chk("prio_u_over_r", 16'h0006);
    pulse(4'b0110, 16'h0002, 4);
    chk("prio_d_over_l", 16'h0004);

    // Wrapping add.
    pulse(4'b1000, 16'hFFFF, 2);
    chk("add_wrap", 16'h0003);

    // Reset between the button rise and the leds update cancels the ADD.
    @(negedge clk); #2;
    switches = 16'h0007;
    btn_v    = 4'b1000;
    @(negedge clk); #2;
    btn_v = 4'b0;
    reset = 1'b0;
    #1;
    chk("midop_reset_now", 16'h0000);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (8) @(negedge clk); #1;
    chk("midop_no_add", 16'h0000);

    // Button held across reset release: exactly one event.
    @(negedge clk); #2;
    reset    = 1'b0;
    switches = 16'h0002;
    btn_v    = 4'b1000;
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (10) @(negedge clk); #2;
    btn_v = 4'b0;
    repeat (6) @(negedge clk); #1;
    chk("held_across_reset", 16'h0002);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter DATA_W, default 16, is the width of the switches, the accumulator and the LEDs.
REQ-002 Parameter SYNC_STAGES, default 2, is the flop depth of every input synchronizer.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: switches  input  DATA_W  asynchronous operand input.
REQ-006 Port: btn_u  input  1  asynchronous button; its rising edge requests ADD.
REQ-007 Port: btn_d  input  1  asynchronous button; its rising edge requests SUB.
REQ-008 Port: btn_l  input  1  asynchronous button; its rising edge requests SHL.
REQ-009 Port: btn_r  input  1  asynchronous button; its rising edge requests LOAD.
REQ-010 Port: leds  output  DATA_W  registered copy of the accumulator.

Function
REQ-011 The four buttons and the switches bus SHALL each pass through a SYNC_STAGES-deep flop synchronizer before use.
REQ-012 A button event SHALL be the synchronized level being 1 while the same signal's previous-cycle registered value is 0, giving one event per rising edge regardless of pulse length.
REQ-013 ADD SHALL set acc to acc + sw_sync modulo 2^DATA_W.
REQ-014 SUB SHALL set acc to acc - sw_sync modulo 2^DATA_W.
REQ-015 SHL SHALL set acc to {acc[DATA_W-2:0], 1'b0}; the MSB is discarded.
REQ-016 LOAD SHALL set acc to sw_sync.
REQ-017 When several events occur in the same cycle, only the highest-priority one SHALL execute (priority u > d > l > r); the others SHALL be dropped.
REQ-018 With no event, acc SHALL hold its value.
REQ-019 leds SHALL equal acc at all times; no combinational path from any input to leds.
REQ-020 Latency: a button first sampled high at rising edge k SHALL update leds at edge k+SYNC_STAGES (edge k+2 by default), using the sw_sync value present in that same cycle.
REQ-021 A button held high continuously SHALL produce no further events until it returns low for at least one synchronized cycle.
REQ-022 Overflow and underflow SHALL wrap silently; there is no status output.

Reset
REQ-023 While reset=0, all synchronizer flops, all previous-value flops and acc SHALL clear to 0 asynchronously, and leds SHALL read 0x0000.
REQ-024 After reset deasserts, a button held high across the deassertion SHALL produce exactly one event, since its synchronizer rises from 0.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight event; no operation SHALL complete after reset assertion.

Structure
REQ-026 The opcode encoding (ADD, SUB, SHL, LOAD, NONE) and the DATA_W default SHALL live in a shared package, top_pkg.
REQ-027 One sub-module, btn_sync_edge, SHALL implement the synchronizer plus rising-edge detect for a single button.
REQ-028 top SHALL instantiate btn_sync_edge four times, synchronize the switches bus inline, and contain the priority encoder and the accumulator register.

Verification
REQ-029 Scenario reset: assert reset=0 with arbitrary inputs -> leds=0x0000 immediately and for as long as reset stays low.
REQ-030 Scenario ADD: switches=0x0003, one btn_u pulse of 10 cycles -> leds=0x0003 two cycles after sampling, with no second increment.
REQ-031 Scenario sequence: from leds=0x0003, pulse btn_d -> 0x0000; pulse btn_l -> 0x0000; pulse btn_d -> 0xFFFD (wrap).
REQ-032 Scenario LOAD and SHL: switches=0x8001, pulse btn_r -> 0x8001; then pulse btn_l -> 0x0002.
REQ-033 Scenario priority: btn_u and btn_r rise in the same cycle with switches=0x0005 and acc=0x0001 -> leds=0x0006 (ADD only).
REQ-034 Scenario reset mid-op: assert reset for 1 cycle between the btn_u rise and the leds update -> leds=0x0000 after the reset pulse, and no ADD occurs from that button press.
